// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the command-driven bus initiator.
//   htrans_t    : transfer type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_t     : transfer size encodings (BYTE/HALF/WORD)
//   HRESP_*     : slave response encodings
//   HPROT_DATA  : fixed protection attributes driven on HPROT
//   HBURST_SINGLE : fixed burst type driven on HBURST
//   misaligned(): flags commands that must not reach the bus
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BYTE = 3'b000,
        HALF = 3'b001,
        WORD = 3'b010
    } hsize_t;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // size 0/1/2 = byte/half/word; size 3 has no legal encoding and is
    // always rejected.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            2'd2:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_lite_master_lanes.sv
// ahb_lite_master_lanes: byte-lane steering for the AHB-Lite initiator.
// Purely combinational.
//   size      in  2  : 0 byte, 1 halfword, 2 word
//   addr_lo   in  2  : address bits [1:0] of the transfer
//   wdata     in  32 : right-justified write data
//   rdata     in  32 : HRDATA as returned by the slave
//   wdata_rep out 32 : write data replicated across all lanes
//   rdata_ext out 32 : addressed lane, right-justified and zero-extended
module ahb_lite_master_lanes
    import ahb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    always_comb begin
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            2'd0: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'd0, rdata[{addr_lo, 3'b000} +: 8]};
            end
            2'd1: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'd0, rdata[{addr_lo[1], 4'b0000} +: 16]};
            end
            default: begin
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: turns a valid/ready command stream into single AHB-Lite
// transfers with overlapped address and data phases, returning one in-order
// response per command.
//   HCLK, HRESET            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake
//   cmd_addr/write/size/wdata : command fields (size 0/1/2 = byte/half/word)
//   rsp_valid/rdata/error   : one-cycle completion pulse, no backpressure
//   HADDR..HMASTLOCK        : AHB-Lite initiator outputs
//   HREADY, HRDATA          : slave inputs
//   HRESP                   : present only when AHB_MASTER_HRESP_EN is defined
// Optional feature macro: AHB_MASTER_HRESP_EN (ERROR response handling with
// cancellation and reissue of the pending address phase).
module ahb_lite_master
    import ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
`ifdef AHB_MASTER_HRESP_EN
    ,
    input  logic        HRESP
`endif
);

    // A slot (address phase)
    logic        vld_p0;
    logic        err_p0;
    logic [31:0] addr_p0;
    logic        write_p0;
    logic [1:0]  size_p0;
    logic [31:0] wdata_p0;

    // D slot (data phase)
    logic        vld_p1;
    logic        err_p1;
    logic [1:0]  addr_lo_p1;
    logic        write_p1;
    logic [1:0]  size_p1;
    logic [31:0] wdata_p1;

    logic        cancel;
    logic        cancel_hold;
    logic        hresp_err;
    logic        a_adv;
    logic        d_done;
    logic        accept;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;

`ifdef AHB_MASTER_HRESP_EN
    // First ERROR cycle: stall. cancel_hold then covers the second cycle,
    // where the pending address phase must be withdrawn (IDLE) and kept
    // for reissue once the error has completed.
    assign cancel    = vld_p1 && (HRESP == HRESP_ERROR) && !HREADY;
    assign hresp_err = (HRESP == HRESP_ERROR);

    always_ff @(posedge HCLK) begin
        if (HRESET)
            cancel_hold <= 1'b0;
        else if (cancel)
            cancel_hold <= 1'b1;
        else if (HREADY)
            cancel_hold <= 1'b0;
    end
`else
    assign cancel      = 1'b0;
    assign cancel_hold = 1'b0;
    assign hresp_err   = 1'b0;
`endif

    assign a_adv     = HREADY && !cancel && !cancel_hold;
    assign d_done    = HREADY && vld_p1;
    assign cmd_ready = !HRESET && (!vld_p0 || a_adv);
    assign accept    = cmd_valid && cmd_ready;

    // ---- stage p0: command accept into A slot ----
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            vld_p0   <= 1'b0;
            err_p0   <= 1'b0;
            addr_p0  <= '0;
            write_p0 <= 1'b0;
            size_p0  <= '0;
            wdata_p0 <= '0;
        end else if (accept) begin
            vld_p0   <= 1'b1;
            err_p0   <= misaligned(cmd_size, cmd_addr[1:0]);
            addr_p0  <= cmd_addr;
            write_p0 <= cmd_write;
            size_p0  <= cmd_size;
            wdata_p0 <= cmd_wdata;
        end else if (a_adv) begin
            vld_p0   <= 1'b0;
        end
    end

    // Misaligned commands travel as IDLE so ordering is kept without
    // touching the bus.
    assign HTRANS    = (vld_p0 && !err_p0 && !cancel_hold) ? NONSEQ : IDLE;
    assign HADDR     = addr_p0;
    assign HWRITE    = write_p0;
    assign HSIZE     = {1'b0, size_p0};
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    // ---- stage p1: A slot to D slot ----
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
            addr_lo_p1 <= '0;
            write_p1   <= 1'b0;
            size_p1    <= '0;
            wdata_p1   <= '0;
        end else if (a_adv) begin
            vld_p1     <= vld_p0;
            err_p1     <= err_p0;
            addr_lo_p1 <= addr_p0[1:0];
            write_p1   <= write_p0;
            size_p1    <= size_p0;
            wdata_p1   <= wdata_p0;
        end else if (d_done) begin
            // Only reached in the second ERROR cycle: D retires, A is held.
            vld_p1     <= 1'b0;
        end
    end

    ahb_lite_master_lanes u_lanes (
        .size      (size_p1),
        .addr_lo   (addr_lo_p1),
        .wdata     (wdata_p1),
        .rdata     (HRDATA),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // D slot registers only change when the slave is ready, so HWDATA is
    // stable across wait states.
    assign HWDATA = (vld_p1 && write_p1 && !err_p1) ? wdata_rep : '0;

    // ---- stage p2: D slot completion into response register ----
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= d_done;
            if (d_done) begin
                rsp_error <= err_p1 || hresp_err;
                rsp_rdata <= (write_p1 || err_p1 || hresp_err) ? '0 : rdata_ext;
            end
        end
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Command-driven AHB-Lite bus initiator. It turns a simple valid/ready command stream into single (non-burst) AHB-Lite transfers, pipelining address and data phases so zero-wait slaves sustain one transfer per cycle. It returns one in-order response per command. It sits between on-chip engines (loader, DMA, test sequencer) and the AHB-Lite interconnect in front of the RAM and peripheral slaves.

## Interface
- No parameters; address and data are fixed at 32 bits.
- HCLK input 1: bus clock; all logic is on the rising edge.
- HRESET input 1: synchronous, active-high reset.
- cmd_valid input 1: command present.
- cmd_ready output 1: command accepted at an edge where valid && ready.
- cmd_addr input 32: byte address.
- cmd_write input 1: 1 = write, 0 = read.
- cmd_size input 2: 0 = byte, 1 = halfword, 2 = word; 3 is treated as misaligned.
- cmd_wdata input 32: write data, right-justified.
- rsp_valid output 1: one-cycle completion pulse. There is no backpressure.
- rsp_rdata output 32: read data, right-justified and zero-extended. It is 0 for writes and errors.
- rsp_error output 1: the command failed.
- HADDR output 32; HTRANS output 2; HWRITE output 1; HSIZE output 3; HWDATA output 32.
- HBURST output 3: constant 3'b000.
- HPROT output 4: constant 4'b0011.
- HMASTLOCK output 1: constant 0.
- HREADY input 1; HRDATA input 32.
- HRESP input 1: present only with AHB_MASTER_HRESP_EN.

## Operation
- The block has two pipeline slots.
  - The A slot (address phase) drives HADDR/HTRANS/HWRITE/HSIZE from registers.
  - The D slot (data phase) holds write data, size, addr[1:0], write flag and error flag.
- `cmd_ready = !HRESET && (!a_valid || (HREADY && !cancel))`. This is combinational on HREADY.
- An accepted command loads the A slot.
  - Misaligned commands are marked err: halfword with addr[0]=1, word with addr[1:0]≠0, or size 3.
  - An err command drives HTRANS=IDLE while in the A slot.
  - Otherwise the A slot drives HTRANS=NONSEQ (2'b10).
- When the A slot is empty, outputs are HTRANS=IDLE and the other address-phase outputs hold their last values.
- At an edge with HREADY=1 (and no cancel), two things happen:
  - The A slot moves to the D slot.
  - The D slot completes and is captured into the response register.
- Response: rsp_valid=1 for one cycle after completion. rsp_error is the err flag, OR'ed with HRESP when enabled.
- HWDATA lane replication from the D slot:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- HWDATA is held stable through wait states and is 0 for reads.
- rsp_rdata lane extraction:
  - byte: HRDATA[8*a+7:8*a] zero-extended, with a = addr[1:0]
  - half: HRDATA[16*a1+15:16*a1] zero-extended, with a1 = addr[1]
  - word: HRDATA unchanged
- Responses are strictly in command order; err commands flow through the pipeline as IDLE transfers.
- Reset mid-transfer clears both slots. In-flight commands produce no response.

## Timing
- Reset values:
  - cmd_ready=0 while HRESET is high.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - HTRANS=IDLE; HADDR, HWRITE, HSIZE and HWDATA all 0.
  - Both slot valids are 0.
- Zero-wait latency:
  - Command accepted at edge E0.
  - Address phase in cycle E0..E1.
  - Data phase in cycle E1..E2.
  - rsp_valid is high in cycle E2..E3.
- Each HREADY=0 cycle in the data phase stalls both slots and adds one cycle of latency.
- Back-to-back commands with HREADY constantly high: HTRANS is NONSEQ on consecutive cycles and throughput is 1 per cycle.
- A command offered while the A slot is full and HREADY=0 is not accepted; cmd_ready=0 that cycle.

## Configuration
- Macro: AHB_MASTER_HRESP_EN.
- With the macro defined, the HRESP port exists and error responses are handled as follows:
  - HRESP=1 && HREADY=0 in the data phase asserts cancel.
  - During cancel, the A slot is held and HTRANS is forced IDLE in the following (second) error cycle.
  - The cancelled command is not lost; it is re-presented as NONSEQ after the error completes.
  - The errored transfer responds with rsp_error=1 and rsp_rdata=0.
- Without the macro:
  - There is no HRESP port and cancel=0.
  - rsp_error reflects misalignment only.

## Structure
- Package ahb_pkg holds:
  - htrans_t: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - hsize_t: BYTE=3'b000, HALF=3'b001, WORD=3'b010.
  - HRESP_OKAY=0, HRESP_ERROR=1.
  - The HPROT and HBURST constants.
- Sub-module ahb_lite_master_lanes is combinational and does write replication and read extraction.

## Test plan
- Word write then read through the team RAM slave:
  - write 0x0000_0010 ← 0xDEADBEEF, then read 0x10.
  - Expect rsp_rdata=0xDEADBEEF with rsp_error=0.
  - Expect 1 extra cycle of write latency from the RAM wait state.
- Byte write:
  - write 0x13 ← 0x000000A5, then word read 0x10 → 0xA5ADBEEF.
  - Byte read 0x13 → 0x000000A5.
  - During the byte write, HWDATA=0xA5A5A5A5.
- Back-to-back: four reads with zero-wait slave and HREADY tied high.
  - Expect HTRANS=NONSEQ on 4 consecutive cycles.
  - Expect four consecutive rsp_valid pulses, in order.
- Misaligned halfword read at 0x21:
  - No NONSEQ on the bus.
  - rsp_error=1, rsp_rdata=0, ordering preserved against neighbouring good commands.
- Wait states and reset:
  - Slave holds HREADY=0 for 3 cycles; HWDATA and the next HADDR stay stable and rsp is delayed 3 cycles.
  - HRESET pulse mid-stall: no response, and all outputs take their reset values the next cycle.
- With AHB_MASTER_HRESP_EN, two-cycle ERROR on a write with a pending read:
  - The write responds with rsp_error=1.
  - HTRANS is IDLE in the second error cycle.
  - The read is reissued and completes with rsp_error=0.
